// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave endpoint and its master peer.
// Mode constants, the default word width and the bit-counter width rule.
package spi_pkg;

  localparam int   SPI_DATA_WIDTH        = 8;
  localparam logic SPI_CPOL_IDLE_LOW     = 1'b0;
  localparam logic SPI_CPHA_TRAIL_SAMPLE = 1'b1;

  // Wide enough to hold every value from 0 to the word width
  function automatic int spi_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a third flop for edge detection of one async pin.
// Not reset: a reset must not fabricate an edge on a pin that did not move.
module spi_sync_edge (
  input  logic clk,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] ff_r;

  // Shift the pin through the synchroniser and the edge-history flop
  always_ff @(posedge clk) begin
    ff_r <= {ff_r[1:0], din};
  end

  assign sync = ff_r[1];
  assign rise = ff_r[1] & ~ff_r[2];
  assign fall = ~ff_r[1] & ff_r[2];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/csn/mosi in the clk domain,
// deserialises mosi into words and serialises data_send onto miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic CPOL       = SPI_CPOL_IDLE_LOW,
  parameter logic CPHA       = SPI_CPHA_TRAIL_SAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_send,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CNT_W = spi_cnt_w(DATA_WIDTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic sclk_rise_s, sclk_fall_s, sclk_sync_s;
  logic csn_rise_s, csn_fall_s, csn_sync_s;
  logic [1:0] mosi_ff_r;
  logic mosi_sync_s;
  logic lead_s, trail_s, sample_s, shift_s;

  logic [0:0]            state_r;
  logic [DATA_WIDTH-1:0] tx_shift_r;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  miso_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r;
  logic                  busy_r;
  logic                  frame_err_r;

  spi_sync_edge u_sclk_sync (
    .clk  (clk),
    .din  (sclk),
    .sync (sclk_sync_s),
    .rise (sclk_rise_s),
    .fall (sclk_fall_s)
  );

  spi_sync_edge u_csn_sync (
    .clk  (clk),
    .din  (csn),
    .sync (csn_sync_s),
    .rise (csn_rise_s),
    .fall (csn_fall_s)
  );

  // Data line only needs the plain two-flop synchroniser
  always_ff @(posedge clk) begin
    mosi_ff_r <= {mosi_ff_r[0], mosi};
  end

  assign mosi_sync_s = mosi_ff_r[1];

  // Map raw sclk edges onto lead/trail, then onto sample/shift for this mode
  always_comb begin
    lead_s   = CPOL ? sclk_fall_s : sclk_rise_s;
    trail_s  = CPOL ? sclk_rise_s : sclk_fall_s;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    if (!csn_sync_s) begin
      sample_s = CPHA ? trail_s : lead_s;
      shift_s  = CPHA ? lead_s : trail_s;
    end else begin
      sample_s = 1'b0;
      shift_s  = 1'b0;
    end
  end

  // Frame control, shifting and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      tx_shift_r  <= {DATA_WIDTH{1'b0}};
      rx_shift_r  <= {DATA_WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      miso_r      <= 1'b0;
      rx_data_r   <= {DATA_WIDTH{1'b0}};
      rx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= ~csn_sync_s;
      case (state_r)
        ST_IDLE: begin
          miso_r    <= 1'b0;
          bit_cnt_r <= {CNT_W{1'b0}};
          if (csn_fall_s) begin
            state_r    <= ST_ACTIVE;
            rx_shift_r <= {DATA_WIDTH{1'b0}};
            // CPHA=0 presents the MSB before the first lead edge
            if (!CPHA) begin
              miso_r     <= data_send[DATA_WIDTH-1];
              tx_shift_r <= {data_send[DATA_WIDTH-2:0], 1'b0};
            end else begin
              tx_shift_r <= data_send;
            end
          end
        end
        ST_ACTIVE: begin
          if (csn_rise_s) begin
            state_r     <= ST_IDLE;
            miso_r      <= 1'b0;
            bit_cnt_r   <= {CNT_W{1'b0}};
            rx_shift_r  <= {DATA_WIDTH{1'b0}};
            frame_err_r <= (bit_cnt_r != {CNT_W{1'b0}});
          end else if (sample_s) begin
            if (bit_cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
              // Word boundary: publish the word and arm the next transmit word
              rx_data_r  <= {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_s};
              rx_valid_r <= 1'b1;
              bit_cnt_r  <= {CNT_W{1'b0}};
              rx_shift_r <= {DATA_WIDTH{1'b0}};
              tx_shift_r <= data_send;
            end else begin
              rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_s};
              bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
            end
          end else if (shift_s) begin
            miso_r     <= tx_shift_r[DATA_WIDTH-1];
            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  assign miso      = miso_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: three instances (CPOL/CPHA = 0/1, 0/0, 1/1) driven by a
// behavioural SPI master; expected words come from the transmitted streams.
module tb_spi_slave;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       sclk_v, csn_v, mosi_v;
  logic [2:0]       miso_v, rxv_v, busy_v, ferr_v;
  logic [2:0][7:0]  ds_v, rxd_v;

  int n_assert = 0;
  int n_fail   = 0;

  int          rx_cnt   [3];
  int          ferr_cnt [3];
  logic [31:0] rx_acc   [3];
  logic [7:0]  last_rx  [3];

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .csn(csn_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .data_send(ds_v[0]), .rx_data(rxd_v[0]),
    .rx_valid(rxv_v[0]), .busy(busy_v[0]), .frame_err(ferr_v[0]));

  spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .csn(csn_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .data_send(ds_v[1]), .rx_data(rxd_v[1]),
    .rx_valid(rxv_v[1]), .busy(busy_v[1]), .frame_err(ferr_v[1]));

  spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .csn(csn_v[2]), .mosi(mosi_v[2]),
    .miso(miso_v[2]), .data_send(ds_v[2]), .rx_data(rxd_v[2]),
    .rx_valid(rxv_v[2]), .busy(busy_v[2]), .frame_err(ferr_v[2]));

  // Observe pulses away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        rx_cnt[d]   <= 0;
        ferr_cnt[d] <= 0;
        rx_acc[d]   <= 32'd0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (rxv_v[d]) begin
          rx_cnt[d] <= rx_cnt[d] + 1;
          rx_acc[d] <= {rx_acc[d][23:0], rxd_v[d]};
        end
        if (ferr_v[d]) ferr_cnt[d] <= ferr_cnt[d] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half_period();
    repeat (8) @(negedge clk);
  endtask

  function automatic logic cpol_of(input int d);
    return (d == 2);
  endfunction

  function automatic logic cpha_of(input int d);
    return (d != 1);
  endfunction

  task automatic pulse_rst(input int d);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_miso", {31'd0, miso_v[d]}, 32'd0);
    check("rst_rx_data", {24'd0, rxd_v[d]}, 32'd0);
    check("rst_rx_valid", {31'd0, rxv_v[d]}, 32'd0);
    check("rst_busy", {31'd0, busy_v[d]}, 32'd0);
    check("rst_frame_err", {31'd0, ferr_v[d]}, 32'd0);
    for (int k = 0; k < 3; k++) last_rx[k] = 8'h00;
  endtask

  // Behavioural master: streams nbits of mo (MSB first), words of sd offered as data_send
  task automatic xfer(input int d, input int nbits, input logic [31:0] mo,
                      input logic [31:0] sd, input int rst_at, output logic [31:0] got);
    logic cpol, cpha;
    int   k;
    cpol = cpol_of(d);
    cpha = cpha_of(d);
    got = 32'd0;
    ds_v[d] = sd[31:24];
    sclk_v[d] = cpol;
    csn_v[d] = 1'b0;
    half_period();
    for (int b = 0; b < nbits; b++) begin
      k = b / 8 + 1;
      if ((b % 8) == 4 && k * 8 < nbits) ds_v[d] = sd[31 - 8 * k -: 8];
      if (b == rst_at) pulse_rst(d);
      if (b == 1) check("busy_mid_frame", {31'd0, busy_v[d]}, (b > rst_at && rst_at >= 0) ? 32'd0 : 32'd1);
      if (!cpha) begin
        mosi_v[d] = mo[31 - b];
        half_period();
        got = {got[30:0], miso_v[d]};
        sclk_v[d] = ~cpol;
        half_period();
        sclk_v[d] = cpol;
      end else begin
        sclk_v[d] = ~cpol;
        mosi_v[d] = mo[31 - b];
        half_period();
        got = {got[30:0], miso_v[d]};
        sclk_v[d] = cpol;
        half_period();
      end
    end
    half_period();
    csn_v[d] = 1'b1;
    half_period();
    half_period();
  endtask

  task automatic run_full(input int d, input int nw, input logic [31:0] mo, input logic [31:0] sd);
    logic [31:0] got, mask;
    int rc0, fc0, nbits;
    nbits = nw * 8;
    mask  = (nw == 4) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    rc0 = rx_cnt[d];
    fc0 = ferr_cnt[d];
    xfer(d, nbits, mo, sd, -1, got);
    check($sformatf("rx_count_d%0d", d), rx_cnt[d] - rc0, nw);
    check($sformatf("rx_words_d%0d", d), rx_acc[d] & mask, mo >> (32 - nbits));
    check($sformatf("miso_words_d%0d", d), got, sd >> (32 - nbits));
    check($sformatf("no_frame_err_d%0d", d), ferr_cnt[d] - fc0, 32'd0);
    last_rx[d] = mo[39 - nbits -: 8];
    check($sformatf("rx_data_hold_d%0d", d), {24'd0, rxd_v[d]}, {24'd0, last_rx[d]});
    check($sformatf("idle_busy_d%0d", d), {31'd0, busy_v[d]}, 32'd0);
    check($sformatf("idle_miso_d%0d", d), {31'd0, miso_v[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int rc0, fc0, d, nw;
    rst = 1'b1;
    sclk_v = 3'b100;
    csn_v  = 3'b111;
    mosi_v = 3'b000;
    ds_v   = '0;
    for (int k = 0; k < 3; k++) last_rx[k] = 8'h00;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_miso", {29'd0, miso_v}, 32'd0);
    check("reset_rx_valid", {29'd0, rxv_v}, 32'd0);
    check("reset_busy", {29'd0, busy_v}, 32'd0);
    check("reset_frame_err", {29'd0, ferr_v}, 32'd0);
    check("reset_rx_data", {8'd0, rxd_v}, 32'd0);

    run_full(0, 1, 32'hA500_0000, 32'h3C00_0000);
    run_full(1, 1, 32'h9A00_0000, 32'h8100_0000);
    run_full(2, 2, 32'h1234_0000, 32'h55AA_0000);

    // csn raised after three bits of 0xF0
    rc0 = rx_cnt[0];
    fc0 = ferr_cnt[0];
    xfer(0, 3, 32'hF000_0000, 32'h0000_0000, -1, got);
    check("abort_frame_err", ferr_cnt[0] - fc0, 32'd1);
    check("abort_no_rx_valid", rx_cnt[0] - rc0, 32'd0);
    check("abort_rx_data_kept", {24'd0, rxd_v[0]}, {24'd0, last_rx[0]});
    check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort_miso", {31'd0, miso_v[0]}, 32'd0);

    // One-cycle reset at bit 5, then a clean word
    xfer(0, 8, 32'hC300_0000, 32'h5A00_0000, 5, got);
    check("rstabort_no_rx_valid", rx_cnt[0], 32'd0);
    check("rstabort_no_frame_err", ferr_cnt[0], 32'd0);
    check("rstabort_rx_data", {24'd0, rxd_v[0]}, 32'd0);
    run_full(0, 1, 32'h0F00_0000, 32'hE700_0000);

    for (int it = 0; it < 9; it++) begin
      d  = it % 3;
      nw = $urandom_range(1, 4);
      run_full(d, nw, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
